shift_add_mul: RTL and testbench

- Sequential unsigned shift-and-add multiplier; the consumer stage directly downstream of the combinational left shifter `SHL`.
- Each cycle it feeds the zero-extended multiplicand and the current bit index into one `SHL` instance, then conditionally accumulates the shifted value.
- It produces a registered 2·DATAWIDTH-bit product after a fixed DATAWIDTH-cycle run.
- It sits in the datapath component library alongside `SHL`, `REG` and the adders, for designs that trade area for latency.

---
 rtl/mul_defs.sv | 18 +
 rtl/shl.sv | 14 +
 rtl/shift_add_mul.sv | 117 +++++++++++
 tb/tb_shift_add_mul.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mul_defs.sv
// Shared definitions for the sequential shift-and-add multiplier: FSM state encoding and
// counter-width helper.
package mul_defs;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Counter width for a given operand width: clog2(width)+1.
   function automatic int unsigned cnt_w(input int unsigned width);
      return $clog2(width) + 1;
   endfunction

   localparam int unsigned DEFAULT_DATAWIDTH = 8;
   localparam int unsigned CNT_W = cnt_w(DEFAULT_DATAWIDTH);

endpackage

// File: rtl/shl.sv
// Combinational logical left shifter from the datapath component library.
module SHL #(
   parameter int unsigned DATAWIDTH = 8
) (
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] sh_amt,
   output logic [DATAWIDTH-1:0] d
);

   always_comb begin
      d = a << sh_amt;
   end

endmodule

// File: rtl/shift_add_mul.sv
// Sequential unsigned shift-and-add multiplier: one partial product per cycle via a single
// SHL instance, 2*DATAWIDTH-bit registered product after DATAWIDTH cycles.
module shift_add_mul
   import mul_defs::*;
#(
   parameter int unsigned DATAWIDTH = 8
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic                     start,
   input  logic [DATAWIDTH-1:0]     a,
   input  logic [DATAWIDTH-1:0]     b,
   output logic                     busy,
   output logic                     done,
   output logic [2*DATAWIDTH-1:0]   prod
);

   localparam int unsigned PW   = 2 * DATAWIDTH;
   localparam int unsigned CW   = cnt_w(DATAWIDTH);
   localparam int unsigned IW   = CW - 1;
   localparam logic [CW-1:0] LAST = CW'(DATAWIDTH - 1);

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [PW-1:0]     a_reg_q, a_reg_d;
   logic [DATAWIDTH-1:0] b_reg_q, b_reg_d;
   logic [PW-1:0]     acc_q, acc_d;
   logic [PW-1:0]     prod_q, prod_d;
   logic              done_q, done_d;

   logic              accept;
   logic              last;
   logic [PW-1:0]     sh_amt;
   logic [PW-1:0]     shifted;

   assign accept = (state_q == IDLE) && start;
   assign last   = (state_q == RUN) && (cnt_q == LAST);
   assign sh_amt = {{(PW - CW){1'b0}}, cnt_q};

   SHL #(
      .DATAWIDTH (PW)
   ) u_shl (
      .a      (a_reg_q),
      .sh_amt (sh_amt),
      .d      (shifted)
   );

   // State register
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (cnt_q == LAST) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs; busy is decoded from the state register so it stays glitch-free and registered.
   always_comb begin
      busy = (state_q == RUN);
      done = done_q;
      prod = prod_q;
   end

   // Datapath next-state
   always_comb begin
      cnt_d   = cnt_q;
      a_reg_d = a_reg_q;
      b_reg_d = b_reg_q;
      acc_d   = acc_q;
      prod_d  = prod_q;
      done_d  = 1'b0;
      if (accept) begin
         a_reg_d = {{DATAWIDTH{1'b0}}, a};
         b_reg_d = b;
         acc_d   = '0;
         cnt_d   = '0;
      end else if (state_q == RUN) begin
         if (b_reg_q[cnt_q[IW-1:0]]) begin
            acc_d = acc_q + shifted;
         end
         cnt_d = cnt_q + 1'b1;
         if (last) begin
            prod_d = acc_d;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         cnt_q   <= '0;
         a_reg_q <= '0;
         b_reg_q <= '0;
         acc_q   <= '0;
         prod_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         a_reg_q <= a_reg_d;
         b_reg_q <= b_reg_d;
         acc_q   <= acc_d;
         prod_q  <= prod_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_shift_add_mul.sv
// Directed self-checking bench for shift_add_mul with DATAWIDTH=8.
module tb_shift_add_mul;

   localparam int unsigned W = 8;

   logic          Clk;
   logic          Rst;
   logic          start;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          busy;
   logic          done;
   logic [2*W-1:0] prod;

   int n_checks;
   int n_fail;

   shift_add_mul #(
      .DATAWIDTH (W)
   ) dut (
      .Clk   (Clk),
      .Rst   (Rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .prod  (prod)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_start(input logic [W-1:0] av, input logic [W-1:0] bv);
      a     = av;
      b     = bv;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Counts edges until done is seen (bounded), and cycles with busy high on the way.
   task automatic wait_done(output int n, output int bc);
      n  = 0;
      bc = 0;
      while (!done && n < 20) begin
         if (busy) bc++;
         tick();
         n++;
      end
   endtask

   task automatic run_mul(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input int exp);
      int n, bc;
      do_start(av, bv);
      wait_done(n, bc);
      check({tag, "_latency"}, n, 8);
      check({tag, "_busy_cycles"}, bc, 8);
      check({tag, "_prod"}, prod, exp);
      check({tag, "_busy_at_done"}, busy, 0);
      tick();
      check({tag, "_done_pulse"}, done, 0);
   endtask

   initial begin
      int n, bc, done_seen, prod_bad;
      n_checks = 0;
      n_fail   = 0;
      start    = 1'b0;
      a        = '0;
      b        = '0;
      Rst      = 1'b1;
      #1;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_prod", prod, 0);
      repeat (2) tick();
      Rst = 1'b0;
      tick();

      run_mul("basic", 8'd13, 8'd11, 143);

      // Hold: prod persists while inputs toggle with no start
      done_seen = 0;
      prod_bad  = 0;
      for (int i = 0; i < 20; i++) begin
         a = 8'(i * 37);
         b = 8'(~i);
         tick();
         if (done) done_seen++;
         if (prod !== 16'd143) prod_bad++;
      end
      check("hold_done", done_seen, 0);
      check("hold_prod_changes", prod_bad, 0);
      check("hold_prod", prod, 143);

      run_mul("max", 8'd255, 8'd255, 65025);
      run_mul("zero", 8'd0, 8'd200, 0);

      // Ignored start while busy
      do_start(8'd3, 8'd5);
      tick();
      tick();
      a     = 8'd7;
      b     = 8'd7;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(n, bc);
      check("ign_latency", n + 3, 8);
      check("ign_prod", prod, 15);
      tick();
      check("ign_done_pulse", done, 0);
      done_seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done) done_seen++;
      end
      check("ign_no_second_done", done_seen, 0);

      // Back-to-back start in the done cycle
      do_start(8'd2, 8'd3);
      wait_done(n, bc);
      check("b2b_first_latency", n, 8);
      check("b2b_first_prod", prod, 6);
      a     = 8'd4;
      b     = 8'd4;
      start = 1'b1;
      check("b2b_done_in_start_cycle", done, 1);
      tick();
      start = 1'b0;
      check("b2b_busy_after_accept", busy, 1);
      check("b2b_prod_held", prod, 6);
      wait_done(n, bc);
      check("b2b_second_latency", n, 8);
      check("b2b_second_prod", prod, 16);
      tick();

      // Reset mid-operation
      do_start(8'd9, 8'd9);
      repeat (3) tick();
      #2;
      Rst = 1'b1;
      #1;
      check("rst_mid_busy", busy, 0);
      check("rst_mid_done", done, 0);
      check("rst_mid_prod", prod, 0);
      tick();
      #3;
      Rst = 1'b0;
      done_seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done || busy) done_seen++;
      end
      check("rst_no_done_after", done_seen, 0);
      run_mul("post_rst", 8'd9, 8'd9, 81);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
